// File: rtl/spi_slave.sv
// SPI mode-0 slave running on the system clock, with synchronised pins and a one-entry TX buffer.
// Optional `SPI_SLAVE_ECHO_EN: on underrun, echo the last received word instead of DEFAULT_RESP.
module spi_slave #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RESP = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q;
  logic [SYNC_STAGES-1:0]  cs_sync_q;
  logic [SYNC_STAGES-1:0]  mosi_sync_q;
  logic                    sclk_prev_q;
  logic                    cs_prev_q;
  logic [CW-1:0]           bit_cnt_q;
  logic [DATA_WIDTH-2:0]   rx_shift_q;
  logic [DATA_WIDTH-1:0]   tx_shift_q;
  logic [DATA_WIDTH-1:0]   buf_q;
  logic                    buf_full_q;
  logic                    miso_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    rx_valid_q;
  logic                    underrun_q;
  logic                    busy_q;

  logic                    sclk_s;
  logic                    cs_s;
  logic                    mosi_s;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    cs_fall;
  logic                    cs_rise;
  logic                    active;
  logic                    word_done;
  logic                    word_start;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic [DATA_WIDTH-1:0]   empty_word;
  logic [DATA_WIDTH-1:0]   start_word_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign active    = (state_q == ACTIVE);

  assign rx_word   = {rx_shift_q, mosi_s};
  assign word_done = active & ~cs_rise & sclk_rise
                   & (bit_cnt_q == CW'(DATA_WIDTH - 1));
  // A completed word with cs still low immediately starts the next one
  assign word_start = (~active & cs_fall) | word_done;

`ifdef SPI_SLAVE_ECHO_EN
  assign empty_word = word_done ? rx_word : rx_data_q;
`else
  assign empty_word = DEFAULT_RESP;
`endif

  assign start_word_d = buf_full_q ? buf_q : empty_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (tx_load && !buf_full_q) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ACTIVE;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else if (sclk_rise) begin
            rx_shift_q <= rx_word[DATA_WIDTH-2:0];
            if (word_done) begin
              bit_cnt_q  <= '0;
              rx_data_q  <= rx_word;
              rx_valid_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end else if (sclk_fall && bit_cnt_q != '0) begin
            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            miso_q     <= tx_shift_q[DATA_WIDTH-2];
          end
        end
      endcase
      if (word_start) begin
        tx_shift_q <= start_word_d;
        miso_q     <= start_word_d[DATA_WIDTH-1];
        if (buf_full_q) begin
          buf_full_q <= 1'b0;
        end else begin
          underrun_q <= 1'b1;
        end
      end
    end
  end

  assign spi_miso    = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = busy_q;

endmodule
